// File: rtl/rvfi_seq_pkg.sv
// rvfi_seq_pkg
//   Shared definitions for the RVFI retire sequencer slice.
//   XLEN / NREG   : default data width and architectural register count
//   seq_state_e   : drain/halt state machine encoding
//   seq_entry_t   : one in-flight instruction {insn, pc} held in the queue
package rvfi_seq_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int INSN_W = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [XLEN-1:0]   pc;
    } seq_entry_t;

endpackage

// File: rtl/rvfi_seq_fifo.sv
// rvfi_seq_fifo
//   Synchronous in-order FIFO with a whole-queue flush.
//   Ports:
//     clock, reset        rising-edge clock, synchronous active-high reset
//     push, push_data     write an entry (ignored while full)
//     pop                 discard the head entry (ignored while empty)
//     flush               empty the queue; beats any push or pop in the same cycle
//     head_data           current head entry (combinational read)
//     full, empty, count  occupancy status
module rvfi_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage needs no reset: an entry is only ever read after it was written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A flush
    // resets everything, so an entry pushed in the flush cycle is lost.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// rvfi_retire_sequencer
//   Pairs fetched instructions with their execute completion for the 2-stage
//   DarkRISCV pipeline and emits one registered RVFI retire record per
//   completed instruction, together with the regfile image seen before it.
//   Ports:
//     clock, reset                 rising-edge clock, synchronous active-high reset
//     issue_valid/insn/pc, issue_ready   fetch-side push handshake
//     exec_done, exec_flush        oldest instruction completes / redirect
//     exec_next_pc, exec_mem_*     completion side data
//     regfile_i                    regfile including this cycle's write
//     drain_req, drain_done        drain-to-halt request and halted indicator
//     retire + record outputs      one-cycle retire record, zero otherwise
//     protocol_err                 sticky: completion seen with an empty queue
module rvfi_retire_sequencer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = rvfi_seq_pkg::XLEN,
    parameter int NREG  = rvfi_seq_pkg::NREG
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [31:0]          issue_insn,
    input  logic [XLEN-1:0]      issue_pc,
    output logic                 issue_ready,
    input  logic                 exec_done,
    input  logic                 exec_flush,
    input  logic [XLEN-1:0]      exec_next_pc,
    input  logic                 exec_mem_req,
    input  logic                 exec_mem_we,
    input  logic [XLEN-1:0]      exec_mem_addr,
    input  logic [XLEN-1:0]      exec_mem_rdata,
    input  logic [XLEN-1:0]      exec_mem_wdata,
    input  logic [3:0]           exec_mem_be,
    input  logic [NREG*XLEN-1:0] regfile_i,
    input  logic                 drain_req,
    output logic                 drain_done,
    output logic                 retire,
    output logic [31:0]          instruction,
    output logic [XLEN-1:0]      old_pc,
    output logic [XLEN-1:0]      new_pc,
    output logic [NREG*XLEN-1:0] old_regfile,
    output logic [NREG*XLEN-1:0] new_regfile,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_rdata,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [3:0]           mem_be,
    output logic                 protocol_err
);

    import rvfi_seq_pkg::*;

    localparam int EW = 32 + XLEN;
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_e          state;
    logic                q_full;
    logic                q_empty;
    logic [CW-1:0]       q_count;
    logic [EW-1:0]       head_entry;
    logic                push;
    logic                pop;
    logic [NREG*XLEN-1:0] snapshot;

    assign issue_ready = !q_full && (state == RUN);
    assign push        = issue_valid && issue_ready;
    assign pop         = exec_done && !q_empty;

    rvfi_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({issue_insn, issue_pc}),
        .pop       (pop),
        .flush     (exec_flush),
        .head_data (head_entry),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Drain FSM. Halting waits until the queue is empty and the last retire
    // record has been presented, so drain_done never overlaps a retire.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RUN;
            drain_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (drain_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state <= RUN;
                    end else if ((q_count == '0) && !retire) begin
                        state      <= HALTED;
                        drain_done <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!drain_req) begin
                        state      <= RUN;
                        drain_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

    // Retire record register. The head entry is read before the pop takes
    // effect, so a completion alongside a flush still retires the head.
    // The snapshot advances on every retire and becomes the next old_regfile.
    always_ff @(posedge clock) begin
        if (reset) begin
            retire       <= 1'b0;
            instruction  <= '0;
            old_pc       <= '0;
            new_pc       <= '0;
            old_regfile  <= '0;
            new_regfile  <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_rdata    <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            snapshot     <= '0;
            protocol_err <= 1'b0;
        end else begin
            retire <= pop;
            if (pop) begin
                instruction <= head_entry[XLEN +: 32];
                old_pc      <= head_entry[XLEN-1:0];
                new_pc      <= exec_next_pc;
                old_regfile <= snapshot;
                new_regfile <= regfile_i;
                mem_req     <= exec_mem_req;
                mem_we      <= exec_mem_we;
                mem_addr    <= exec_mem_addr;
                mem_rdata   <= exec_mem_rdata;
                mem_wdata   <= exec_mem_wdata;
                mem_be      <= exec_mem_be;
                snapshot    <= regfile_i;
            end else begin
                instruction <= '0;
                old_pc      <= '0;
                new_pc      <= '0;
                old_regfile <= '0;
                new_regfile <= '0;
                mem_req     <= 1'b0;
                mem_we      <= 1'b0;
                mem_addr    <= '0;
                mem_rdata   <= '0;
                mem_wdata   <= '0;
                mem_be      <= '0;
            end
            if (exec_done && q_empty) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
// tb_rvfi_retire_sequencer
//   Directed scenarios followed by a randomized run, all compared against a
//   queue-based reference model of the retire sequencer.
module tb_rvfi_retire_sequencer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int RFW   = NREG * XLEN;

    logic            clock = 1'b0;
    logic            reset;
    logic            issue_valid;
    logic [31:0]     issue_insn;
    logic [XLEN-1:0] issue_pc;
    logic            issue_ready;
    logic            exec_done;
    logic            exec_flush;
    logic [XLEN-1:0] exec_next_pc;
    logic            exec_mem_req;
    logic            exec_mem_we;
    logic [XLEN-1:0] exec_mem_addr;
    logic [XLEN-1:0] exec_mem_rdata;
    logic [XLEN-1:0] exec_mem_wdata;
    logic [3:0]      exec_mem_be;
    logic [RFW-1:0]  regfile_i;
    logic            drain_req;
    logic            drain_done;
    logic            retire;
    logic [31:0]     instruction;
    logic [XLEN-1:0] old_pc;
    logic [XLEN-1:0] new_pc;
    logic [RFW-1:0]  old_regfile;
    logic [RFW-1:0]  new_regfile;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            protocol_err;

    rvfi_retire_sequencer #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .NREG  (NREG)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_insn     (issue_insn),
        .issue_pc       (issue_pc),
        .issue_ready    (issue_ready),
        .exec_done      (exec_done),
        .exec_flush     (exec_flush),
        .exec_next_pc   (exec_next_pc),
        .exec_mem_req   (exec_mem_req),
        .exec_mem_we    (exec_mem_we),
        .exec_mem_addr  (exec_mem_addr),
        .exec_mem_rdata (exec_mem_rdata),
        .exec_mem_wdata (exec_mem_wdata),
        .exec_mem_be    (exec_mem_be),
        .regfile_i      (regfile_i),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .retire         (retire),
        .instruction    (instruction),
        .old_pc         (old_pc),
        .new_pc         (new_pc),
        .old_regfile    (old_regfile),
        .new_regfile    (new_regfile),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .protocol_err   (protocol_err)
    );

    always #5 clock = ~clock;

    // Reference model: in-flight instructions as a plain queue, plus the
    // regfile image last handed out and the expected retire record.
    typedef struct {
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
    } model_entry_t;

    model_entry_t    model_q[$];
    logic [RFW-1:0]  model_snap;
    logic            e_retire;
    logic [31:0]     e_insn;
    logic [XLEN-1:0] e_old_pc;
    logic [XLEN-1:0] e_new_pc;
    logic [RFW-1:0]  e_old_rf;
    logic [RFW-1:0]  e_new_rf;
    logic            e_mreq;
    logic            e_mwe;
    logic [XLEN-1:0] e_maddr;
    logic [XLEN-1:0] e_mrdata;
    logic [XLEN-1:0] e_mwdata;
    logic [3:0]      e_mbe;
    logic            e_perr;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic checkOutput(input string tag, input logic [RFW-1:0] observed,
                               input logic [RFW-1:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearRecord();
        e_retire = 1'b0;
        e_insn   = '0;
        e_old_pc = '0;
        e_new_pc = '0;
        e_old_rf = '0;
        e_new_rf = '0;
        e_mreq   = 1'b0;
        e_mwe    = 1'b0;
        e_maddr  = '0;
        e_mrdata = '0;
        e_mwdata = '0;
        e_mbe    = '0;
    endtask

    task automatic clearModel();
        model_q.delete();
        model_snap = '0;
        e_perr     = 1'b0;
        clearRecord();
    endtask

    task automatic checkRecord(input string step);
        checkOutput({step, ".retire"},       RFW'(retire),       RFW'(e_retire));
        checkOutput({step, ".instruction"},  RFW'(instruction),  RFW'(e_insn));
        checkOutput({step, ".old_pc"},       RFW'(old_pc),       RFW'(e_old_pc));
        checkOutput({step, ".new_pc"},       RFW'(new_pc),       RFW'(e_new_pc));
        checkOutput({step, ".old_regfile"},  old_regfile,        e_old_rf);
        checkOutput({step, ".new_regfile"},  new_regfile,        e_new_rf);
        checkOutput({step, ".mem_req"},      RFW'(mem_req),      RFW'(e_mreq));
        checkOutput({step, ".mem_we"},       RFW'(mem_we),       RFW'(e_mwe));
        checkOutput({step, ".mem_addr"},     RFW'(mem_addr),     RFW'(e_maddr));
        checkOutput({step, ".mem_rdata"},    RFW'(mem_rdata),    RFW'(e_mrdata));
        checkOutput({step, ".mem_wdata"},    RFW'(mem_wdata),    RFW'(e_mwdata));
        checkOutput({step, ".mem_be"},       RFW'(mem_be),       RFW'(e_mbe));
        checkOutput({step, ".protocol_err"}, RFW'(protocol_err), RFW'(e_perr));
    endtask

    task automatic setMem(input logic req, input logic we, input logic [XLEN-1:0] addr,
                          input logic [XLEN-1:0] rdata, input logic [XLEN-1:0] wdata,
                          input logic [3:0] be);
        exec_mem_req   = req;
        exec_mem_we    = we;
        exec_mem_addr  = addr;
        exec_mem_rdata = rdata;
        exec_mem_wdata = wdata;
        exec_mem_be    = be;
    endtask

    // Drives one cycle of stimulus, advances the model across the clock edge
    // and returns #1 after the edge. The bench keeps issue_valid low whenever
    // the sequencer is not in its normal running mode.
    task automatic applyStimulus(input logic iv, input logic [31:0] insn,
                                 input logic [XLEN-1:0] pc, input logic done,
                                 input logic flush, input logic [XLEN-1:0] npc,
                                 input logic drq);
        model_entry_t ent;
        logic can_push;
        issue_valid  = iv;
        issue_insn   = insn;
        issue_pc     = pc;
        exec_done    = done;
        exec_flush   = flush;
        exec_next_pc = npc;
        drain_req    = drq;
        can_push = iv && (model_q.size() < DEPTH);
        if (done && model_q.size() > 0) begin
            ent      = model_q.pop_front();
            e_retire = 1'b1;
            e_insn   = ent.insn;
            e_old_pc = ent.pc;
            e_new_pc = npc;
            e_old_rf = model_snap;
            e_new_rf = regfile_i;
            e_mreq   = exec_mem_req;
            e_mwe    = exec_mem_we;
            e_maddr  = exec_mem_addr;
            e_mrdata = exec_mem_rdata;
            e_mwdata = exec_mem_wdata;
            e_mbe    = exec_mem_be;
            model_snap = regfile_i;
        end else begin
            clearRecord();
            if (done) begin
                e_perr = 1'b1;
            end
        end
        if (flush) begin
            model_q.delete();
        end else if (can_push) begin
            ent.insn = insn;
            ent.pc   = pc;
            model_q.push_back(ent);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic doReset(input logic done_during);
        reset       = 1'b1;
        issue_valid = 1'b0;
        exec_done   = done_during;
        exec_flush  = 1'b0;
        drain_req   = 1'b0;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        exec_done = 1'b0;
        clearModel();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waited;
        logic [RFW-1:0] rf;
        logic [XLEN-1:0] x1_val;

        issue_insn   = '0;
        issue_pc     = '0;
        exec_next_pc = '0;
        regfile_i    = '0;
        setMem(1'b0, 1'b0, '0, '0, '0, 4'h0);
        doReset(1'b0);

        $display("[TB] reset state");
        checkRecord("reset");
        checkOutput("reset.issue_ready", RFW'(issue_ready), RFW'(1'b1));
        checkOutput("reset.drain_done", RFW'(drain_done), RFW'(1'b0));

        $display("[TB] single instruction retire");
        applyStimulus(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkRecord("single.issue");
        setMem(1'b1, 1'b1, 32'h100, 32'h0, 32'hdead_beef, 4'hf);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 1'b0);
        setMem(1'b0, 1'b0, '0, '0, '0, 4'h0);
        checkRecord("single.retire");
        checkOutput("single.insn_const", RFW'(instruction), RFW'(32'h00500093));
        checkOutput("single.new_pc_const", RFW'(new_pc), RFW'(32'h4));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkRecord("single.idle");

        $display("[TB] fill queue to full");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i), 32'h40 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b0);
        end
        checkOutput("full.issue_ready", RFW'(issue_ready), RFW'(1'b0));
        applyStimulus(1'b1, 32'h0bad_0bad, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("full.still_not_ready", RFW'(issue_ready), RFW'(1'b0));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 1'b0);
        checkRecord("full.pop0");
        checkOutput("full.ready_after_pop", RFW'(issue_ready), RFW'(1'b1));
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44 + 32'(4 * i), 1'b0);
            checkRecord("full.pop");
        end

        $display("[TB] completion on empty queue");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkRecord("perr.set");
        checkOutput("perr.const", RFW'(protocol_err), RFW'(1'b1));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkRecord("perr.sticky");
        doReset(1'b0);
        checkOutput("perr.cleared", RFW'(protocol_err), RFW'(1'b0));

        $display("[TB] completion with flush");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h2000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b0);
        end
        applyStimulus(1'b1, 32'h2fff, 32'h2fc, 1'b1, 1'b1, 32'h300, 1'b0);
        checkRecord("flush.head");
        checkOutput("flush.insn_const", RFW'(instruction), RFW'(32'h2000));
        checkOutput("flush.ready", RFW'(issue_ready), RFW'(1'b1));
        applyStimulus(1'b1, 32'h3000, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h304, 1'b0);
        checkRecord("flush.after");
        checkOutput("flush.after_insn_const", RFW'(instruction), RFW'(32'h3000));

        $display("[TB] reset while a retire is pending");
        applyStimulus(1'b1, 32'h4000, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
        doReset(1'b1);
        checkRecord("midreset");
        checkOutput("midreset.ready", RFW'(issue_ready), RFW'(1'b1));

        $display("[TB] drain to halt");
        applyStimulus(1'b1, 32'h5000, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h5001, 32'h504, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("drain.ready", RFW'(issue_ready), RFW'(1'b0));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h504 + 32'(4 * i), 1'b1);
            checkRecord("drain.pop");
            checkOutput("drain.not_done_yet", RFW'(drain_done), RFW'(1'b0));
        end
        waited = 0;
        while (drain_done !== 1'b1 && waited < 10) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkRecord("drain.wait");
            waited++;
        end
        checkOutput("drain.done", RFW'(drain_done), RFW'(1'b1));
        checkOutput("drain.halted_ready", RFW'(issue_ready), RFW'(1'b0));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("drain.resume_done", RFW'(drain_done), RFW'(1'b0));
        checkOutput("drain.resume_ready", RFW'(issue_ready), RFW'(1'b1));

        $display("[TB] regfile snapshot");
        doReset(1'b0);
        regfile_i = '0;
        applyStimulus(1'b1, 32'h00500093, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h00700113, 32'h14, 1'b0, 1'b0, 32'h0, 1'b0);
        rf = '0;
        rf[(NREG - 2) * XLEN +: XLEN] = 32'd5;
        regfile_i = rf;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h14, 1'b0);
        checkRecord("rf.first");
        x1_val = new_regfile[(NREG - 2) * XLEN +: XLEN];
        checkOutput("rf.new_x1", RFW'(x1_val), RFW'(32'd5));
        rf[(NREG - 3) * XLEN +: XLEN] = 32'd7;
        regfile_i = rf;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h18, 1'b0);
        checkRecord("rf.second");
        x1_val = old_regfile[(NREG - 2) * XLEN +: XLEN];
        checkOutput("rf.old_x1", RFW'(x1_val), RFW'(32'd5));

        $display("[TB] randomized traffic");
        doReset(1'b0);
        for (int i = 0; i < 400; i++) begin
            logic iv;
            logic done;
            logic flush;
            for (int r = 0; r < NREG; r++) begin
                regfile_i[(NREG - 1 - r) * XLEN +: XLEN] = $urandom;
            end
            setMem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                   $urandom, $urandom, 4'($urandom_range(0, 15)));
            iv    = 1'($urandom_range(0, 1));
            done  = ($urandom_range(0, 2) != 0) &&
                    (model_q.size() > 0 || $urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 9) == 0);
            checkOutput("rand.issue_ready", RFW'(issue_ready), RFW'(model_q.size() < DEPTH));
            applyStimulus(iv, $urandom, $urandom, done, flush, $urandom, 1'b0);
            checkRecord("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
